// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared constants for the sequential restoring divider.
//   - FSM state encodings (IDLE, RUN, FIX, DONE) as plain 2-bit localparams.
//   - cnt_width(): iteration counter width for a given operand width.
// -----------------------------------------------------------------------------
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;  // signed sign fix-up, only with DIV_SIGNED_EN
  localparam logic [1:0] ST_DONE = 2'd3;

  // Counter must be able to hold 0..W.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// -----------------------------------------------------------------------------
// div_trial_sub
//   Combinational (W+1)-bit trial subtract for one restoring-divide step.
//   Ports:
//     i_a      [W:0]   shifted partial remainder P'
//     i_b      [W:0]   zero-extended divisor {1'b0, B}
//     o_t      [W-1:0] low W bits of T = P' - B (the new remainder when kept)
//     o_borrow         T[W]; 1 means P' < B and the step must restore P'
// -----------------------------------------------------------------------------
module div_trial_sub #(
  parameter int W = 4
) (
  input  logic [W:0]   i_a,
  input  logic [W:0]   i_b,
  output logic [W-1:0] o_t,
  output logic         o_borrow
);

  logic [W:0] w_diff;

  assign w_diff   = i_a - i_b;
  // While P < B holds, P' < 2B, so a non-negative difference always fits in
  // W bits and the top bit of the (W+1)-bit difference is exactly the borrow.
  assign o_t      = w_diff[W-1:0];
  assign o_borrow = w_diff[W];

endmodule

// File: rtl/div_restoring_seq.sv
// -----------------------------------------------------------------------------
// div_restoring_seq
//   Sequential restoring divider: A / B -> quotient Q, remainder R, one trial
//   subtract per clock. Optional signed mode via macro DIV_SIGNED_EN
//   (truncating division, one extra fix-up cycle, overflow flag V).
//
//   Handshake: start is sampled on a rising clk edge and accepted only when
//   the unit is not busy (IDLE or DONE); A and B are captured on that edge.
//   busy is high while iterating. done rises together with busy falling and
//   stays high, with Q/R/DZ/V stable, until the next accepted start, which
//   drops done on the same edge.
//
//   Ports:
//     clk, rst      clock; asynchronous active-high reset
//     start         divide request
//     A, B [W-1:0]  dividend, divisor
//     busy, done    status
//     Q, R [W-1:0]  quotient, remainder
//     DZ            divide-by-zero flag
//     V             signed overflow (tied 0 without DIV_SIGNED_EN)
//     dbg_state     current FSM state (div_pkg ST_* encodings)
// -----------------------------------------------------------------------------
module div_restoring_seq
  import div_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         DZ,
  output logic         V,
  output logic [1:0]   dbg_state
);

  localparam int CNT_W = cnt_width(W);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_p;      // partial remainder (top bit of P is always 0 here)
  logic [W-1:0]     r_dq;     // dividend shifts out the top, quotient in the bottom
  logic [W-1:0]     r_b;      // divisor (magnitude in signed mode)
  logic [W-1:0]     r_a;      // original dividend, returned as R on divide-by-zero
  logic             r_zero;   // accepted divide had B == 0
  logic [W-1:0]     r_q;
  logic [W-1:0]     r_r;
  logic             r_dz;
  logic             r_v;

  logic             w_accept;
  logic             w_last;
  logic [W:0]       w_p_shift;
  logic [W-1:0]     w_t;
  logic             w_borrow;
  logic [W-1:0]     w_p_next;
  logic [W-1:0]     w_dq_next;
  logic [W-1:0]     w_a_mag;
  logic [W-1:0]     w_b_mag;

  assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last    = (r_cnt == CNT_W'(W - 1));
  assign w_p_shift = {r_p, r_dq[W-1]};

  div_trial_sub #(.W(W)) u_trial_sub (
    .i_a      (w_p_shift),
    .i_b      ({1'b0, r_b}),
    .o_t      (w_t),
    .o_borrow (w_borrow)
  );

  // Restore on borrow; otherwise keep the difference and record a 1.
  assign w_p_next  = w_borrow ? w_p_shift[W-1:0] : w_t;
  assign w_dq_next = {r_dq[W-2:0], ~w_borrow};

`ifdef DIV_SIGNED_EN
  logic r_neg_q;   // operand signs differ -> negate quotient
  logic r_neg_r;   // dividend negative     -> negate remainder
  logic r_ovf;     // most-negative / -1

  // Two's complement magnitude; the most-negative value maps to 2^(W-1),
  // which is still correct as an unsigned W-bit magnitude.
  assign w_a_mag = A[W-1] ? (~A + W'(1)) : A;
  assign w_b_mag = B[W-1] ? (~B + W'(1)) : B;
`else
  assign w_a_mag = A;
  assign w_b_mag = B;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_dq    <= '0;
      r_b     <= '0;
      r_a     <= '0;
      r_zero  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
      r_v     <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_a     <= A;
            r_b     <= w_b_mag;
            r_dq    <= w_a_mag;
            r_p     <= '0;
            r_cnt   <= '0;
            r_zero  <= (B == '0);
            r_dz    <= 1'b0;
            r_v     <= 1'b0;
            r_state <= ST_RUN;
`ifdef DIV_SIGNED_EN
            r_neg_q <= A[W-1] ^ B[W-1];
            r_neg_r <= A[W-1];
            r_ovf   <= (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);
`endif
          end
        end

        ST_RUN: begin
          if (r_zero) begin
            // Divide-by-zero skips iteration and completes after one busy cycle.
            r_q     <= '1;
            r_r     <= r_a;
            r_dz    <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_p   <= w_p_next;
            r_dq  <= w_dq_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
`ifdef DIV_SIGNED_EN
              r_state <= ST_FIX;
`else
              r_q     <= w_dq_next;
              r_r     <= w_p_next;
              r_state <= ST_DONE;
`endif
            end
          end
        end

`ifdef DIV_SIGNED_EN
        ST_FIX: begin
          // Most-negative / -1 already yields Q = most-negative here via
          // wrap-around; only the overflow flag needs setting.
          r_q     <= r_neg_q ? (~r_dq + W'(1)) : r_dq;
          r_r     <= r_neg_r ? (~r_p + W'(1)) : r_p;
          r_v     <= r_ovf;
          r_state <= ST_DONE;
        end
`endif

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == ST_RUN) || (r_state == ST_FIX);
  assign done      = (r_state == ST_DONE);
  assign Q         = r_q;
  assign R         = r_r;
  assign DZ        = r_dz;
  assign V         = r_v;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_div_restoring_seq.sv
module tb_div_restoring_seq;

  localparam int W  = 8;
  localparam int EW = 8 + 2 * W + 2;   // {busy_cycles, Q, R, DZ, V}
`ifdef DIV_SIGNED_EN
  localparam int BUSY_N = W + 1;
`else
  localparam int BUSY_N = W;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, DZ, V;
  logic [W-1:0] Q, R;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  div_restoring_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Q         (Q),
    .R         (R),
    .DZ        (DZ),
    .V         (V),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack(input int bc, input logic [W-1:0] q,
                                         input logic [W-1:0] r, input logic dz, input logic v);
    return {8'(bc), q, r, dz, v};
  endfunction

  // Monitor: count busy cycles, pop and compare on each rising done.
  int   busy_cnt = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
        chk("done_low_while_busy", {31'd0, done}, 32'd0);
      end
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("busy_cycles", busy_cnt, {24'd0, e[EW-1 -: 8]});
          chk("Q", {24'd0, Q}, {24'd0, e[2*W+1 -: W]});
          chk("R", {24'd0, R}, {24'd0, e[W+1 -: W]});
          chk("DZ", {31'd0, DZ}, {31'd0, e[1]});
          chk("V", {31'd0, V}, {31'd0, e[0]});
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int bc,
                        input logic [W-1:0] q, input logic [W-1:0] r,
                        input logic dz, input logic v);
    @(negedge clk);
    start = 1'b1;
    A     = a;
    B     = b;
    exp_q.push_back(pack(bc, q, r, dz, v));
    @(negedge clk);
    start = 1'b0;
    A     = $urandom_range(0, 255);
    B     = $urandom_range(0, 255);
    wait_done("div");
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_Q", {24'd0, Q}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div(8'd100, 8'd7, BUSY_N, 8'd14, 8'd2, 1'b0, 1'b0);
    do_div(8'd5,   8'd0, 1,      8'hFF, 8'd5, 1'b1, 1'b0);
    do_div(8'd9,   8'd3, BUSY_N, 8'd3,  8'd0, 1'b0, 1'b0);
    do_div(8'd3,   8'd9, BUSY_N, 8'd0,  8'd3, 1'b0, 1'b0);
    do_div(8'd0,   8'd5, BUSY_N, 8'd0,  8'd0, 1'b0, 1'b0);
`ifdef DIV_SIGNED_EN
    do_div(8'hF9,  8'd2,  BUSY_N, 8'hFD, 8'hFF, 1'b0, 1'b0);  // -7 / 2
    do_div(8'h80,  8'hFF, BUSY_N, 8'h80, 8'h00, 1'b0, 1'b1);  // -128 / -1
    do_div(8'd7,   8'hFE, BUSY_N, 8'hFD, 8'd1,  1'b0, 1'b0);  // 7 / -2
    do_div(8'hF9,  8'hFE, BUSY_N, 8'd3,  8'hFF, 1'b0, 1'b0);  // -7 / -2
    do_div(8'hFF,  8'd1,  BUSY_N, 8'hFF, 8'd0,  1'b0, 1'b0);  // -1 / 1
`else
    do_div(8'd255, 8'd1,   BUSY_N, 8'd255, 8'd0, 1'b0, 1'b0);
    do_div(8'd255, 8'd255, BUSY_N, 8'd1,   8'd0, 1'b0, 1'b0);
    do_div(8'd200, 8'd13,  BUSY_N, 8'd15,  8'd5, 1'b0, 1'b0);
`endif

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    start = 1'b1; A = 8'd100; B = 8'd7;
    exp_q.push_back(pack(BUSY_N, 8'd14, 8'd2, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; A = 8'd1; B = 8'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start");
    repeat (2) @(negedge clk);

    // start held high through DONE: back-to-back divides
    @(negedge clk);
    start = 1'b1; A = 8'd20; B = 8'd6;
    exp_q.push_back(pack(BUSY_N, 8'd3, 8'd2, 1'b0, 1'b0));
    wait_done("b2b_0");
    A = 8'd50; B = 8'd7;
    exp_q.push_back(pack(BUSY_N, 8'd7, 8'd1, 1'b0, 1'b0));
    wait_done("b2b_1");
    A = 8'd120; B = 8'd13;
    exp_q.push_back(pack(BUSY_N, 8'd9, 8'd3, 1'b0, 1'b0));
    wait_done("b2b_2");
    start = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; A = 8'd100; B = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_Q", {24'd0, Q}, 32'd0);
    chk("mid_rst_R", {24'd0, R}, 32'd0);
    chk("mid_rst_DZ", {31'd0, DZ}, 32'd0);
    chk("mid_rst_V", {31'd0, V}, 32'd0);
    chk("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (BUSY_N + 3) @(negedge clk);
    chk("idle_after_rst_done", {31'd0, done}, 32'd0);

    // a fresh divide still works after reset
    do_div(8'd9, 8'd3, BUSY_N, 8'd3, 8'd0, 1'b0, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
